// File: rtl/reg_out_seq_pkg.sv
// Shared types and constants for the output-register write sequencer.
//   seq_state_e : sequencer FSM states
//   cmd_t       : queued write command {addr, data}
//   init_cmd()  : returns the idx-th command of the post-reset init sequence
package reg_out_seq_pkg;

  localparam int unsigned N_DATA      = 16;
  localparam int unsigned N_DIR       = 4;
  localparam int unsigned ADDR_W      = 5;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned INIT_WRITES = 20;

  localparam logic [ADDR_W-1:0] DIR_BASE = 5'd16;
  localparam logic [ADDR_W-1:0] DIR_LAST = 5'd19;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_SETUP  = 3'd2,
    S_STROBE = 3'd3,
    S_HOLD   = 3'd4
  } seq_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  localparam int unsigned CMD_W = $bits(cmd_t);

  // Init order: direction regs 0..3 first, then data regs 0..15 cleared.
  function automatic cmd_t init_cmd(input logic [ADDR_W-1:0] idx, input logic [7:0] dir_lo);
    cmd_t c;
    if (idx < ADDR_W'(N_DIR)) begin
      c.addr = DIR_BASE + idx;
      c.data = {8'h00, dir_lo};
    end else begin
      c.addr = idx - ADDR_W'(N_DIR);
      c.data = '0;
    end
    return c;
  endfunction

endpackage

// File: rtl/reg_out_seq_if.sv
// Host write channel plus output-register-unit drive signals.
//   slave  : sequencer view (accepts host writes, drives the unit)
//   master : host/observer view
interface reg_out_seq_if;
  import reg_out_seq_pkg::*;

  logic                wr_valid;
  logic                wr_ready;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W-1:0]   data_out;
  logic [N_DATA-1:0]   sel;
  logic [N_DIR-1:0]    sel_dir;
  logic                busy;
  logic                init_done;
  logic                err_addr;
  logic                err_clr;

  modport slave (
    input  wr_valid, wr_addr, wr_data, err_clr,
    output wr_ready, data_out, sel, sel_dir, busy, init_done, err_addr
  );

  modport master (
    output wr_valid, wr_addr, wr_data, err_clr,
    input  wr_ready, data_out, sel, sel_dir, busy, init_done, err_addr
  );

endinterface

// File: rtl/reg_out_cmd_fifo.sv
// Synchronous command FIFO; an entry is readable the cycle after its push.
//   clk, rst_n        : clock, async active-low reset (flushes pointers/count)
//   push_i, wdata_i   : write port (ignored when full)
//   pop_i, rdata_o    : read port, rdata_o shows the head entry (ignored when empty)
//   full_o, empty_o   : registered level flags
//   count_o           : current number of entries
module reg_out_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 21,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             push_ok, pop_ok;

  assign push_ok = push_i & ~full_q;
  assign pop_ok  = pop_i & ~empty_q;
  assign count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);

  // Pointer/count/flag state; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage array, no reset needed: validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/reg_out_seq_ctrl.sv
// Write sequencer in front of the output-register unit. Host writes are queued
// and replayed as SETUP / STROBE (STB_CYCLES) / HOLD with exactly one select
// strobe active; an optional init sequence runs first after reset.
//   clk, rst_n : clock, async active-low reset
//   bus        : host handshake (wr_*), unit drive (data_out, sel, sel_dir),
//                status (busy, init_done, err_addr) and err_clr
module reg_out_seq_ctrl
  import reg_out_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STB_CYCLES = 2,
  parameter logic [7:0]  INIT_DIR   = 8'h00,
  parameter bit          INIT_EN    = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_out_seq_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  seq_state_e        state_q, state_d;
  logic [3:0]        stb_cnt_q, stb_cnt_d;
  logic [ADDR_W-1:0] init_idx_q, init_idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [N_DATA-1:0] sel_q, sel_d;
  logic [N_DIR-1:0]  sel_dir_q, sel_dir_d;
  logic              init_done_q, init_done_d;
  logic              err_addr_q, err_addr_d;

  logic              wr_hs, addr_legal;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  cmd_t              fifo_wdata, fifo_rdata, next_cmd;
  logic [CNT_W-1:0]  fifo_count;
  logic              init_phase, next_avail;

  // Host handshake: illegal addresses are acknowledged but dropped.
  assign wr_hs      = bus.wr_valid & ~fifo_full;
  assign addr_legal = (bus.wr_addr <= DIR_LAST);
  assign fifo_push  = wr_hs & addr_legal;
  assign fifo_wdata = '{addr: bus.wr_addr, data: bus.wr_data};

  reg_out_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Command source: init table until init completes, then the host FIFO.
  assign init_phase = INIT_EN & ~init_done_q;
  assign next_cmd   = init_phase ? init_cmd(init_idx_q, INIT_DIR) : fifo_rdata;
  assign next_avail = init_phase ? (init_idx_q != ADDR_W'(INIT_WRITES)) : ~fifo_empty;

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT_EN ? S_INIT : S_IDLE;
      stb_cnt_q   <= '0;
      init_idx_q  <= '0;
      addr_q      <= '0;
      data_out_q  <= '0;
      sel_q       <= '0;
      sel_dir_q   <= '0;
      init_done_q <= 1'b0;
      err_addr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      stb_cnt_q   <= stb_cnt_d;
      init_idx_q  <= init_idx_d;
      addr_q      <= addr_d;
      data_out_q  <= data_out_d;
      sel_q       <= sel_d;
      sel_dir_q   <= sel_dir_d;
      init_done_q <= init_done_d;
      err_addr_q  <= err_addr_d;
    end
  end

  // Next-state and output logic; selects default low so only STROBE drives them.
  always_comb begin
    state_d    = state_q;
    stb_cnt_d  = stb_cnt_q;
    init_idx_d = init_idx_q;
    addr_d     = addr_q;
    data_out_d = data_out_q;
    sel_d      = '0;
    sel_dir_d  = '0;
    fifo_pop   = 1'b0;

    case (state_q)
      S_INIT, S_IDLE, S_HOLD: begin
        if (next_avail) begin
          state_d    = S_SETUP;
          addr_d     = next_cmd.addr;
          data_out_d = next_cmd.data;
          if (init_phase) init_idx_d = init_idx_q + ADDR_W'(1);
          else            fifo_pop   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        state_d   = S_STROBE;
        stb_cnt_d = 4'(STB_CYCLES - 1);
        if (addr_q < DIR_BASE)       sel_d     = N_DATA'(1) << addr_q[3:0];
        else if (addr_q <= DIR_LAST) sel_dir_d = N_DIR'(1) << addr_q[1:0];
      end
      S_STROBE: begin
        if (stb_cnt_q == 4'd0) begin
          state_d = S_HOLD;
        end else begin
          stb_cnt_d = stb_cnt_q - 4'd1;
          sel_d     = sel_q;
          sel_dir_d = sel_dir_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    init_done_d = init_done_q | (state_d == S_IDLE);

    // Sticky error: a new illegal write outranks a same-cycle clear.
    err_addr_d = err_addr_q;
    if (wr_hs && !addr_legal) err_addr_d = 1'b1;
    else if (bus.err_clr)     err_addr_d = 1'b0;
  end

  assign bus.wr_ready  = ~fifo_full;
  assign bus.data_out  = data_out_q;
  assign bus.sel       = sel_q;
  assign bus.sel_dir   = sel_dir_q;
  assign bus.busy      = (state_q != S_IDLE) | (fifo_count != '0);
  assign bus.init_done = init_done_q;
  assign bus.err_addr  = err_addr_q;

endmodule

// File: tb/tb_reg_out_seq_ctrl.sv
// Scoreboard bench for reg_out_seq_ctrl: stimulus pushes expected strobe pulses,
// a negedge monitor pops and checks each pulse as it appears on sel/sel_dir.
module tb_reg_out_seq_ctrl;

  localparam int unsigned STB = 2;

  typedef struct packed {
    logic [15:0] sel;
    logic [3:0]  dir;
    logic [15:0] data;
    logic        cp;     // check start-to-start period against the previous pulse
  } exp_t;

  logic clk;
  logic rst_n;
  reg_out_seq_if bus ();

  reg_out_seq_ctrl #(
    .FIFO_DEPTH (4),
    .STB_CYCLES (STB),
    .INIT_DIR   (8'h00),
    .INIT_EN    (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  bit   saw_stall = 0;
  int   end_cyc = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Pulse monitor
  bit          in_pulse = 0;
  bit          have_prev = 0;
  int          width = 0;
  int          prev_start = 0;
  logic [15:0] cur_sel, cur_data;
  logic [3:0]  cur_dir;
  exp_t        e;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_pulse  = 0;
      have_prev = 0;
    end else begin
      chk("onehot", 32'($countones({bus.sel, bus.sel_dir}) <= 1), 32'd1);
      if (!in_pulse && (bus.sel != 16'h0 || bus.sel_dir != 4'h0)) begin
        in_pulse = 1;
        width    = 1;
        cur_sel  = bus.sel;
        cur_dir  = bus.sel_dir;
        cur_data = bus.data_out;
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {12'h0, bus.sel_dir, bus.sel}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_sel", 32'(bus.sel), 32'(e.sel));
          chk("pulse_sel_dir", 32'(bus.sel_dir), 32'(e.dir));
          chk("pulse_data", 32'(bus.data_out), 32'(e.data));
          if (e.cp && have_prev) chk("pulse_period", 32'(cyc - prev_start), 32'(STB + 2));
        end
        prev_start = cyc;
        have_prev  = 1;
      end else if (in_pulse) begin
        if (bus.sel == cur_sel && bus.sel_dir == cur_dir) begin
          width++;
          chk("data_stable", 32'(bus.data_out), 32'(cur_data));
        end else begin
          in_pulse = 0;
          end_cyc  = cyc;
          chk("pulse_width", 32'(width), 32'(STB));
          chk("hold_data", 32'(bus.data_out), 32'(cur_data));
        end
      end
    end
  end

  task automatic push_init();
    for (int i = 0; i < 4; i++)
      exp_q.push_back('{sel: 16'h0, dir: 4'(1 << i), data: 16'h0000, cp: (i != 0)});
    for (int i = 0; i < 16; i++)
      exp_q.push_back('{sel: 16'(1 << i), dir: 4'h0, data: 16'h0000, cp: 1'b1});
  endtask

  // Drives one request at the next negedge and returns just after the accepting edge.
  task automatic do_write(input logic [4:0] a, input logic [15:0] d, input logic [15:0] es,
                          input logic [3:0] ed, input bit legal, input bit cp, input bit clr);
    bit done = 0;
    @(negedge clk);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    bus.err_clr  = clr;
    for (int n = 0; n < 64 && !done; n++) begin
      if (bus.wr_ready) begin
        if (legal) exp_q.push_back('{sel: es, dir: ed, data: d, cp: cp});
        @(posedge clk);
        done = 1;
      end else begin
        saw_stall = 1;
        @(negedge clk);
      end
    end
    chk("wr_handshake", 32'(done), 32'd1);
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    bus.wr_valid = 1'b0;
    bus.err_clr  = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int n = 0; n < 400 && !idle; n++) begin
      @(negedge clk);
      if (!bus.busy) idle = 1;
    end
    chk("idle_reached", 32'(idle), 32'd1);
  endtask

  logic [15:0] b_data [6] = '{16'h1100, 16'h2201, 16'h3302, 16'h4403, 16'h5504, 16'h6605};
  logic [15:0] b_sel  [6] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020};

  initial begin
    rst_n        = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.err_clr  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_sel", 32'(bus.sel), 32'h0);
    chk("rst_sel_dir", 32'(bus.sel_dir), 32'h0);
    chk("rst_data_out", 32'(bus.data_out), 32'h0);
    chk("rst_err_addr", 32'(bus.err_addr), 32'h0);
    chk("rst_init_done", 32'(bus.init_done), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h1);
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'h1);

    // Init sequence: IDLE entered on the 81st edge after release
    push_init();
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    chk("init_done_early", 32'(bus.init_done), 32'h0);
    @(negedge clk);
    chk("init_done_set", 32'(bus.init_done), 32'h1);
    chk("init_busy_low", 32'(bus.busy), 32'h0);
    chk("init_all_pulses", 32'(exp_q.size()), 32'd0);

    // Single write, latency: SETUP after E1, strobe from E2
    do_write(5'd5, 16'h00A5, 16'h0020, 4'h0, 1, 0, 0);
    idle_inputs();
    chk("lat_e0_sel", 32'(bus.sel), 32'h0);
    @(negedge clk);
    chk("lat_setup_sel", 32'(bus.sel), 32'h0);
    chk("lat_setup_data", 32'(bus.data_out), 32'h00A5);
    @(negedge clk);
    chk("lat_strobe_sel", 32'(bus.sel), 32'h0020);
    wait_idle();

    // Burst of 6 with wr_valid held; FIFO fills and back-pressures
    saw_stall = 0;
    for (int i = 0; i < 6; i++)
      do_write(5'(i), b_data[i], b_sel[i], 4'h0, 1, (i != 0), 0);
    idle_inputs();
    chk("burst_stall", 32'(saw_stall), 32'd1);
    begin
      bit idle = 0;
      for (int n = 0; n < 200 && !idle; n++) begin
        if (!bus.busy) idle = 1;
        else @(negedge clk);
      end
      chk("burst_idle", 32'(idle), 32'd1);
      chk("busy_fall", 32'(cyc - end_cyc), 32'd1);
    end
    chk("burst_all_pulses", 32'(exp_q.size()), 32'd0);
    chk("burst_ready_back", 32'(bus.wr_ready), 32'h1);

    // Illegal address handling
    do_write(5'd22, 16'h0BAD, 16'h0, 4'h0, 0, 0, 0);
    idle_inputs();
    chk("err_set", 32'(bus.err_addr), 32'h1);
    chk("err_no_busy", 32'(bus.busy), 32'h0);
    repeat (3) @(negedge clk);
    chk("err_sticky", 32'(bus.err_addr), 32'h1);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    chk("err_cleared", 32'(bus.err_addr), 32'h0);
    do_write(5'd31, 16'h1111, 16'h0, 4'h0, 0, 0, 0);
    idle_inputs();
    chk("err_set2", 32'(bus.err_addr), 32'h1);
    do_write(5'd20, 16'h2222, 16'h0, 4'h0, 0, 0, 1);
    idle_inputs();
    chk("err_set_wins", 32'(bus.err_addr), 32'h1);
    repeat (8) @(negedge clk);

    // Direction register write, CLR bit carried through
    do_write(5'd17, 16'h8003, 16'h0, 4'b0010, 1, 0, 0);
    idle_inputs();
    wait_idle();
    chk("dir_all_pulses", 32'(exp_q.size()), 32'd0);

    // Reset during STROBE with a second command queued
    do_write(5'd3, 16'h1234, 16'h0008, 4'h0, 1, 0, 0);
    do_write(5'd4, 16'h5678, 16'h0010, 4'h0, 1, 1, 0);
    idle_inputs();
    begin
      bit hit = 0;
      for (int n = 0; n < 20 && !hit; n++) begin
        if (bus.sel != 16'h0) hit = 1;
        else @(negedge clk);
      end
      chk("mid_strobe_seen", 32'(hit), 32'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_sel", 32'(bus.sel), 32'h0);
    chk("mrst_sel_dir", 32'(bus.sel_dir), 32'h0);
    chk("mrst_data_out", 32'(bus.data_out), 32'h0);
    chk("mrst_init_done", 32'(bus.init_done), 32'h0);
    chk("mrst_wr_ready", 32'(bus.wr_ready), 32'h1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    push_init();
    rst_n = 1'b1;
    wait_idle();
    chk("rerun_init_done", 32'(bus.init_done), 32'h1);
    chk("rerun_all_pulses", 32'(exp_q.size()), 32'd0);
    repeat (10) @(negedge clk);
    chk("no_stale_cmd", 32'(bus.busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_out_seq_ctrl.md
Name: reg_out_seq_ctrl

Overview:
Write sequencer placed in front of the output-register unit. It drives that unit's shared 16-bit data bus, its 16 data-register select strobes and its 4 direction-register select strobes. Host writes are queued in a small command FIFO. Each write is replayed as a setup/strobe/hold sequence with exactly one select active. After reset, an optional init sequence programs every direction register and clears every data register before host traffic is served.

Parameters:
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
STB_CYCLES, 2, select strobe width in clocks (1..15)
INIT_DIR, 8'h00, low byte written to all 4 direction registers during init
INIT_EN, 1, 1 = run init sequence after reset; 0 = go straight to IDLE

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
wr_valid  in  1  host write request
wr_ready  out  1  host handshake; = !fifo_full
wr_addr  in  5  0..15 data reg, 16..19 dir reg, 20..31 illegal
wr_data  in  16  write data; bit 15 = CLR, passed through unchanged
data_out  out  16  to unit data_in
sel  out  16  one-hot data-register strobes (bit n -> sel_n)
sel_dir  out  4  one-hot dir-register strobes
busy  out  1  FSM not IDLE or FIFO non-empty
init_done  out  1  set on first entry to IDLE, held until reset
err_addr  out  1  sticky illegal-address flag
err_clr  in  1  clears err_addr

Behaviour:
- Reset (async assert): data_out=0, sel=0, sel_dir=0, err_addr=0, init_done=0, FIFO flushed, FSM=INIT (INIT_EN=1) or IDLE (INIT_EN=0). busy=1 while in INIT.
- Handshake: transfer occurs on an edge where wr_valid & wr_ready. Legal addresses are enqueued as {addr, data}. Illegal addresses complete the handshake but are not enqueued; err_addr=1 from the next cycle.
- err_addr: err_clr clears it. If err_clr and a new illegal write occur in the same cycle, set wins.
- FIFO: registered, so an entry is visible the cycle after the push. Push and pop in the same cycle are allowed at any level, including DEPTH-1. No push occurs when full because wr_ready=0.
- FSM states: INIT, IDLE, SETUP, STROBE, HOLD.
- IDLE: if FIFO non-empty, pop, latch addr/data, load data_out, go to SETUP. Otherwise stay; data_out holds its last value and sel/sel_dir=0.
- SETUP: 1 cycle. data_out valid, all selects 0. Then go to STROBE.
- STROBE: STB_CYCLES cycles. Exactly one select bit high: sel[addr] for addr<16, sel_dir[addr-16] for 16..19. data_out stable. Strobe counter is 4 bits.
- HOLD: 1 cycle, selects 0, data_out unchanged. If FIFO non-empty, pop and go directly to SETUP (data_out loads the new value on that edge). Otherwise go to IDLE.
- Timing: back-to-back throughput is one write per STB_CYCLES+2 clocks. Latency from the accepting edge E0 with the FSM idle: SETUP entered at E1, select high from E2.
- INIT: 20 internal writes with the same SETUP/STROBE/HOLD timing, in this order:
  - dir 0..3 with data {8'h00, INIT_DIR};
  - then data regs 0..15 with 16'h0000.
  Host pushes are accepted during INIT; they are served only after init completes. Init takes 20*(STB_CYCLES+2) clocks, then IDLE and init_done=1.
- Invariants: never more than one of the 20 select bits high. No select is high in SETUP, HOLD or IDLE.
- Reset mid-sequence: all selects drop to 0 immediately (async). Queued commands are lost. INIT restarts on release.

Decomposition:
- Package reg_out_seq_pkg holds:
  - FSM state enum;
  - N_DATA=16, N_DIR=4, DIR_BASE=5'd16, DIR_LAST=5'd19;
  - command struct {addr[4:0], data[15:0]};
  - init write count 20.
- One sub-module: reg_out_cmd_fifo (parameterised synchronous FIFO with full/empty/count, async active-low reset).
- Address decode and strobe generation stay in the top.

Test Plan:
- INIT_EN=1, STB_CYCLES=2, release reset -> sel_dir pulses 1,2,4,8, then sel 0x0001..0x8000 in order. Each pulse is 2 cycles wide with a 4-cycle period. data_out=0x0000 throughout (INIT_DIR=0). init_done rises after 80 clocks.
- After init, write addr 5, data 0x00A5 -> sel=0x0020 high for exactly 2 cycles, starting 2 edges after the handshake. data_out=0x00A5 from one cycle before to one cycle after the strobe.
- Burst of 6 writes, addr 0..5, FIFO_DEPTH=4, wr_valid held -> wr_ready drops while 4 entries are queued. All 6 strobes appear in order with a 4-cycle period and no idle gap. busy falls one cycle after the last HOLD.
- Write addr 22 -> handshake completes, no select pulse, err_addr=1 and held. Pulse err_clr -> 0. Illegal write together with err_clr -> err_addr stays 1.
- Write addr 17, data 0x8003 -> sel_dir=4'b0010 for 2 cycles, sel=0, data_out=0x8003 (CLR bit preserved).
- Assert rst_n low during STROBE -> sel/sel_dir/data_out are 0 within the same cycle, the FIFO is empty, and the INIT sequence reruns from dir 0 after release.
